// File: rtl/pc_reg.sv
// pc_reg: program-counter register for the single-cycle RV64 core, async active-high reset.
// Defining PC_MISALIGN_CHK_EN adds a registered 'misaligned' flag that tracks pc_in[1:0] != 0.
module pc_reg #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
`ifdef PC_MISALIGN_CHK_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] pc_out
);

  // Full-width capture on every edge: no enable, no masking, no arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out <= RESET_VECTOR;
    end else begin
      pc_out <= pc_in;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  // Flag is captured alongside pc_out; the PC itself is still stored unmasked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= (pc_in[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: self-checking bench for pc_reg; timed scenarios plus randomized traffic
// compared against a "last value present at the edge" reference model.
`timescale 1ns/1ps
module tb_pc_reg;
  localparam int unsigned     XLEN = 64;
  localparam logic [XLEN-1:0] RV   = 64'h0;

  logic            clk   = 1'b0;
  logic            rst   = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic [XLEN-1:0] pc_out;
`ifdef PC_MISALIGN_CHK_EN
  logic            misaligned;
`endif

  int tests = 0;
  int fails = 0;
  bit watch4 = 1'b0;
  bit seen4  = 1'b0;

  pc_reg #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
`ifdef PC_MISALIGN_CHK_EN
    .misaligned(misaligned),
`endif
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  always @(pc_out) if (watch4 && pc_out === 64'd4) seen4 = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [XLEN-1:0] rand_pc();
    logic [XLEN-1:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: rand_pc = v - (v % 4);
      1: rand_pc = v;
      2: rand_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      default: rand_pc = 64'(4 * $urandom_range(0, 255) + $urandom_range(0, 3));
    endcase
  endfunction

  // Timeline with edges at 5, 15, 25 ns.
  task automatic test_spec_timeline();
    #6;
    tests++;
    if (pc_out !== 64'd0) begin
      fails++; $display("FAIL initial_load: got %h want %h", pc_out, 64'd0);
    end
    watch4 = 1'b1;
    #6 pc_in = 64'd4;
    #1;
    tests++;
    if (pc_out !== 64'd0) begin
      fails++; $display("FAIL hold_before_edge: got %h want %h", pc_out, 64'd0);
    end
    #1 pc_in = 64'd8;
    #2;
    tests++;
    if (pc_out !== 64'd8) begin
      fails++; $display("FAIL last_value_wins: got %h want %h", pc_out, 64'd8);
    end
    watch4 = 1'b0;
    tests++;
    if (seen4 !== 1'b0) begin
      fails++; $display("FAIL never_showed_4: seen4=%0b want 0", seen4);
    end
    pc_in = 64'd12;
    #2 pc_in = 64'd16;
    #1;
    tests++;
    if (pc_out !== 64'd8) begin
      fails++; $display("FAIL between_edge_ignored: got %h want %h", pc_out, 64'd8);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (pc_out !== RV) begin
      fails++; $display("FAIL async_reset: got %h want %h", pc_out, RV);
    end
    #1 pc_in = 64'd20;
    #1;
    tests++;
    if (pc_out !== RV) begin
      fails++; $display("FAIL reset_holds: got %h want %h", pc_out, RV);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (pc_out !== RV) begin
      fails++; $display("FAIL release_no_change: got %h want %h", pc_out, RV);
    end
    pc_in = 64'd24;
    #2;
    tests++;
    if (pc_out !== 64'd24) begin
      fails++; $display("FAIL first_load_after_release: got %h want %h", pc_out, 64'd24);
    end
  endtask

  // Reset asserted mid-cycle and held across several edges with changing pc_in.
  task automatic test_reset();
    logic [XLEN-1:0] v;
    @(negedge clk) pc_in = rand_pc();
    #2 rst = 1'b1;
    #1;
    tests++;
    if (pc_out !== RV) begin
      fails++; $display("FAIL reset_midcycle: got %h want %h", pc_out, RV);
    end
`ifdef PC_MISALIGN_CHK_EN
    tests++;
    if (misaligned !== 1'b0) begin
      fails++; $display("FAIL reset_misaligned: got %0b want 0", misaligned);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) pc_in = rand_pc();
      @(posedge clk) #1;
      tests++;
      if (pc_out !== RV) begin
        fails++; $display("FAIL reset_ignores_edge[%0d]: got %h want %h", i, pc_out, RV);
      end
    end
    @(negedge clk) rst = 1'b0;
    v = rand_pc();
    pc_in = v;
    @(posedge clk) #1;
    tests++;
    if (pc_out !== v) begin
      fails++; $display("FAIL reset_release_load: got %h want %h", pc_out, v);
    end
  endtask

  // Random traffic: multiple in-cycle changes, occasional short reset pulses.
  task automatic test_random();
    logic [XLEN-1:0] last;
    int              nchg;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      nchg = $urandom_range(1, 3);
      last = rand_pc();
      pc_in = last;
      for (int k = 1; k < nchg; k++) begin
        #1;
        last = rand_pc();
        pc_in = last;
      end
      if ($urandom_range(0, 9) == 0) begin
        #1 rst = 1'b1;
        #1;
        tests++;
        if (pc_out !== RV) begin
          fails++; $display("FAIL rand_reset_pulse[%0d]: got %h want %h", i, pc_out, RV);
        end
        rst = 1'b0;
      end
      @(posedge clk) #1;
      tests++;
      if (pc_out !== last) begin
        fails++; $display("FAIL rand_load[%0d]: got %h want %h", i, pc_out, last);
      end
`ifdef PC_MISALIGN_CHK_EN
      tests++;
      if (misaligned !== ((last % 4) != 0)) begin
        fails++;
        $display("FAIL rand_misaligned[%0d]: got %0b want %0b", i, misaligned, (last % 4) != 0);
      end
`endif
    end
  endtask

  // Every consecutive edge loads, including across the top of the address space.
  task automatic test_back_to_back();
    logic [XLEN-1:0] v;
    v = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) pc_in = v;
      @(posedge clk) #1;
      tests++;
      if (pc_out !== v) begin
        fails++; $display("FAIL back_to_back[%0d]: got %h want %h", i, pc_out, v);
      end
      v = v + 64'd4;
    end
  endtask

  // Reset asserted in the same timestep as a clock edge: reset must win.
  task automatic test_reset_at_edge();
    @(negedge clk) pc_in = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk) rst = 1'b1;
    #1;
    tests++;
    if (pc_out !== RV) begin
      fails++; $display("FAIL reset_at_edge: got %h want %h", pc_out, RV);
    end
    @(negedge clk) rst = 1'b0;
  endtask

`ifdef PC_MISALIGN_CHK_EN
  task automatic test_misalign();
    @(negedge clk) pc_in = 64'h2;
    @(posedge clk) #1;
    tests++;
    if (misaligned !== 1'b1 || pc_out !== 64'h2) begin
      fails++; $display("FAIL misalign_set: got mis=%0b pc=%h want mis=1 pc=2", misaligned, pc_out);
    end
    @(negedge clk) pc_in = 64'h4;
    @(posedge clk) #1;
    tests++;
    if (misaligned !== 1'b0) begin
      fails++; $display("FAIL misalign_clear: got %0b want 0", misaligned);
    end
    @(negedge clk) pc_in = 64'h7;
    @(posedge clk) #1;
    tests++;
    if (misaligned !== 1'b1) begin
      fails++; $display("FAIL misalign_set2: got %0b want 1", misaligned);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (misaligned !== 1'b0) begin
      fails++; $display("FAIL misalign_reset: got %0b want 0", misaligned);
    end
    @(negedge clk) rst = 1'b0;
  endtask
`endif

  initial begin
    test_spec_timeline();
    test_reset();
    test_random();
    test_back_to_back();
    test_reset_at_edge();
`ifdef PC_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
